// File: rtl/gpio_checkpoint_monitor.sv
// Checkpoint sequencer for the user-project GPIO outputs. A programmed list of
// checkbit/status values must appear in order on gpio_in, each held stable for
// STABLE_CYCLES synchronized samples, with an optional per-step timeout.
module gpio_checkpoint_monitor #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_W     = 24,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [19:0]          gpio_in,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [15:0]          cfg_value,
  input  logic                 cfg_sel,
  input  logic                 cfg_tol,
  input  logic [AW:0]          cfg_count,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 matched,
  output logic [AW-1:0]        cur_index,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout
);

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StArmed, StPass, StFail} state_e;

  // Input conditioning
  logic [19:0] s1_q, s2_q, s3_q;
  logic [3:0]  stab_cnt_q;
  logic        stable;

  // Sequencer state
  state_e               state_q, state_d;
  logic [AW-1:0]        index_q, index_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic [AW:0]          count_q, count_d;
  logic                 matched_q, matched_d;
  logic                 tflag_q, tflag_d;

  // Entry storage {sel, tol, value}; deliberately not reset so it survives runs
  logic [17:0] mem_q [DEPTH];
  logic [17:0] entry;
  logic [15:0] val_inc;
  logic [3:0]  st_inc;
  logic        entry_hit;
  logic        last_entry;
  logic        timer_hit;

  // Two-flop synchronizer, history flop and stability counter
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      stab_cnt_q <= '0;
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (s2_q != s3_q) begin
        stab_cnt_q <= '0;
      end else if (stab_cnt_q != StableMax) begin
        stab_cnt_q <= stab_cnt_q + 4'd1;
      end
    end
  end

  assign stable = (stab_cnt_q == StableMax);

  // Register-file writes, blocked while a sequence is armed
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && (state_q != StArmed)) begin
      mem_q[cfg_addr] <= {cfg_sel, cfg_tol, cfg_value};
    end
  end

  // Match rule against the stable sample, with optional +1 tolerance
  always_comb begin
    entry     = mem_q[index_q];
    val_inc   = entry[15:0] + 16'd1;
    st_inc    = entry[3:0] + 4'd1;
    entry_hit = 1'b0;
    if (entry[17]) begin
      entry_hit = (s3_q[19:16] == entry[3:0]) || (entry[16] && (s3_q[19:16] == st_inc));
    end else begin
      entry_hit = (s3_q[15:0] == entry[15:0]) || (entry[16] && (s3_q[15:0] == val_inc));
    end
  end

  assign last_entry = ({1'b0, index_q} == (count_q - (AW + 1)'(1)));
  assign timer_hit  = (limit_q != '0) && (timer_q == limit_q);

  // Sequencer next-state: abort first, then start/match/timeout
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    timer_d   = timer_q;
    limit_d   = limit_q;
    count_d   = count_q;
    matched_d = 1'b0;
    tflag_d   = tflag_q;
    if (abort) begin
      state_d = StIdle;
      index_d = '0;
      timer_d = '0;
      tflag_d = 1'b0;
    end else begin
      case (state_q)
        StIdle, StPass, StFail: begin
          if (start) begin
            count_d = cfg_count;
            limit_d = cfg_timeout;
            index_d = '0;
            timer_d = '0;
            tflag_d = 1'b0;
            state_d = (cfg_count == '0) ? StPass : StArmed;
          end
        end
        StArmed: begin
          // A match wins over a timeout in the same cycle
          if (stable && entry_hit) begin
            matched_d = 1'b1;
            index_d   = index_q + AW'(1);
            timer_d   = '0;
            if (last_entry) begin
              state_d = StPass;
            end
          end else if (timer_hit) begin
            state_d = StFail;
            tflag_d = 1'b1;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TIMEOUT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      index_q   <= '0;
      timer_q   <= '0;
      limit_q   <= '0;
      count_q   <= '0;
      matched_q <= 1'b0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      timer_q   <= timer_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      matched_q <= matched_d;
      tflag_q   <= tflag_d;
    end
  end

  assign busy      = (state_q == StArmed);
  assign pass      = (state_q == StPass);
  assign fail      = (state_q == StFail);
  assign matched   = matched_q;
  assign cur_index = index_q;
  assign timeout   = tflag_q;

endmodule

// File: tb/tb_gpio_checkpoint_monitor.sv
// Self-checking bench: expected matched pulses (cycle, index) are queued when
// stimulus is driven and compared against pulses recorded by a monitor.
module tb_gpio_checkpoint_monitor;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [19:0] gpio_in;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_value;
  logic        cfg_sel;
  logic        cfg_tol;
  logic [3:0]  cfg_count;
  logic [23:0] cfg_timeout;
  logic        start;
  logic        abort;
  logic        busy;
  logic        matched;
  logic [2:0]  cur_index;
  logic        pass;
  logic        fail;
  logic        timeout;

  gpio_checkpoint_monitor #(
    .DEPTH         (8),
    .STABLE_CYCLES (4),
    .TIMEOUT_W     (24)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .gpio_in     (gpio_in),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_value   (cfg_value),
    .cfg_sel     (cfg_sel),
    .cfg_tol     (cfg_tol),
    .cfg_count   (cfg_count),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .matched     (matched),
    .cur_index   (cur_index),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Count of rising edges seen so far
  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   obs_rd = 0;

  // Monitor: records every matched pulse with its cycle and the index it left
  int obs_cyc [128];
  int obs_idx [128];
  int obs_wr = 0;
  always @(negedge wb_clk_i) begin
    if (wb_rst_i === 1'b0 && matched === 1'b1) begin
      obs_cyc[obs_wr % 128] <= cyc;
      obs_idx[obs_wr % 128] <= int'(cur_index);
      obs_wr <= obs_wr + 1;
    end
  end

  task automatic program_entry(input int a, input bit sel, input bit tol,
                               input logic [15:0] v);
    @(negedge wb_clk_i);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_sel   = sel;
    cfg_tol   = tol;
    cfg_value = v;
    @(negedge wb_clk_i);
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input int c, input int t);
    @(negedge wb_clk_i);
    cfg_count   = 4'(c);
    cfg_timeout = 24'(t);
    start       = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  // Drive v for n samples; a qualifying hold matches 7 edges after first sample
  task automatic hold(input logic [19:0] v, input int n, input bit exp_m, input int idx);
    exp_t e;
    @(negedge wb_clk_i);
    gpio_in = v;
    if (exp_m) begin
      e.cyc = cyc + 8;
      e.idx = idx;
      exp_q.push_back(e);
    end
    repeat (n - 1) @(negedge wb_clk_i);
  endtask

  task automatic program_basic();
    program_entry(0, 1'b0, 1'b0, 16'hAB40);
    program_entry(1, 1'b1, 1'b0, 16'h000A);
    program_entry(2, 1'b1, 1'b0, 16'h0005);
    program_entry(3, 1'b0, 1'b1, 16'h1968);
    program_entry(4, 1'b0, 1'b0, 16'hAB51);
  endtask

  task automatic drive_basic();
    hold({4'h0, 16'hAB40}, 10, 1'b1, 1);
    hold({4'hA, 16'h0000}, 10, 1'b1, 2);
    hold({4'h5, 16'h0000}, 10, 1'b1, 3);
    hold({4'h0, 16'h1968}, 10, 1'b1, 4);
    hold({4'h0, 16'hAB51}, 10, 1'b1, 5);
  endtask

  task automatic test_reset();
    wb_rst_i    = 1'b1;
    gpio_in     = '0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_value   = '0;
    cfg_sel     = 1'b0;
    cfg_tol     = 1'b0;
    cfg_count   = '0;
    cfg_timeout = '0;
    start       = 1'b0;
    abort       = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if ({busy, matched, pass, fail, timeout} !== 5'b0 || cur_index !== 3'd0)
      $display("FAIL reset_outputs: busy=%b matched=%b pass=%b fail=%b timeout=%b idx=%0d, want all 0",
               busy, matched, pass, fail, timeout, cur_index);
    else passed++;
    wb_rst_i = 1'b0;
    repeat (8) @(negedge wb_clk_i);
  endtask

  task automatic test_basic();
    exp_t e;
    program_basic();
    start_seq(5, 0);
    checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: busy=%b, want 1", busy);
    else passed++;
    drive_basic();
    repeat (4) @(negedge wb_clk_i);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin
        $display("FAIL basic_match: no pulse, want cycle %0d idx %0d", e.cyc, e.idx);
      end else begin
        if (obs_cyc[obs_rd % 128] !== e.cyc || obs_idx[obs_rd % 128] !== e.idx)
          $display("FAIL basic_match: cycle %0d idx %0d, want cycle %0d idx %0d",
                   obs_cyc[obs_rd % 128], obs_idx[obs_rd % 128], e.cyc, e.idx);
        else passed++;
        obs_rd++;
      end
    end
    checks++;
    if (obs_rd != obs_wr) begin
      $display("FAIL basic_extra: %0d extra pulses, want 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end else passed++;
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || fail !== 1'b0)
      $display("FAIL basic_final: pass=%b busy=%b fail=%b, want 1 0 0", pass, busy, fail);
    else passed++;
  endtask

  task automatic test_abort();
    exp_t e;
    start_seq(5, 0);
    hold({4'h0, 16'hAB40}, 10, 1'b1, 1);
    hold({4'hA, 16'h0000}, 10, 1'b1, 2);
    @(negedge wb_clk_i);
    checks++;
    if (cur_index !== 3'd2 || busy !== 1'b1)
      $display("FAIL abort_pre: idx=%0d busy=%b, want 2 1", cur_index, busy);
    else passed++;
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    checks++;
    if ({busy, pass, fail, timeout} !== 4'b0 || cur_index !== 3'd0)
      $display("FAIL abort_flags: busy=%b pass=%b fail=%b timeout=%b idx=%0d, want all 0",
               busy, pass, fail, timeout, cur_index);
    else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin
        $display("FAIL abort_match: no pulse, want cycle %0d idx %0d", e.cyc, e.idx);
      end else begin
        if (obs_cyc[obs_rd % 128] !== e.cyc || obs_idx[obs_rd % 128] !== e.idx)
          $display("FAIL abort_match: cycle %0d idx %0d, want cycle %0d idx %0d",
                   obs_cyc[obs_rd % 128], obs_idx[obs_rd % 128], e.cyc, e.idx);
        else passed++;
        obs_rd++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    hold(20'h0, 10, 1'b0, 0);
    start_seq(5, 0);
    hold({4'h0, 16'hAB40}, 10, 1'b1, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    checks++;
    if ({busy, matched, pass, fail, timeout} !== 5'b0 || cur_index !== 3'd0)
      $display("FAIL reset_midrun: busy=%b pass=%b fail=%b idx=%0d, want all 0",
               busy, pass, fail, cur_index);
    else passed++;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    // Re-start without reprogramming: stored entries must survive the reset
    hold(20'h0, 10, 1'b0, 0);
    start_seq(5, 0);
    drive_basic();
    repeat (4) @(negedge wb_clk_i);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin
        $display("FAIL reuse_match: no pulse, want cycle %0d idx %0d", e.cyc, e.idx);
      end else begin
        if (obs_cyc[obs_rd % 128] !== e.cyc || obs_idx[obs_rd % 128] !== e.idx)
          $display("FAIL reuse_match: cycle %0d idx %0d, want cycle %0d idx %0d",
                   obs_cyc[obs_rd % 128], obs_idx[obs_rd % 128], e.cyc, e.idx);
        else passed++;
        obs_rd++;
      end
    end
    checks++;
    if (obs_rd != obs_wr) begin
      $display("FAIL reuse_extra: %0d extra pulses, want 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end else passed++;
    checks++;
    if (pass !== 1'b1) $display("FAIL reuse_pass: pass=%b, want 1", pass);
    else passed++;
  endtask

  task automatic test_tolerance();
    exp_t e;
    program_entry(0, 1'b0, 1'b1, 16'h1968);
    program_entry(1, 1'b1, 1'b1, 16'h000F);
    hold({4'h3, 16'h0000}, 10, 1'b0, 0);
    start_seq(2, 0);
    hold({4'h3, 16'h196A}, 12, 1'b0, 0);
    checks++;
    if (cur_index !== 3'd0 || busy !== 1'b1)
      $display("FAIL tol_plus2: idx=%0d busy=%b, want 0 1", cur_index, busy);
    else passed++;
    hold({4'h3, 16'h1969}, 10, 1'b1, 1);
    hold({4'h0, 16'h1969}, 10, 1'b1, 2);
    repeat (4) @(negedge wb_clk_i);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin
        $display("FAIL tol_match: no pulse, want cycle %0d idx %0d", e.cyc, e.idx);
      end else begin
        if (obs_cyc[obs_rd % 128] !== e.cyc || obs_idx[obs_rd % 128] !== e.idx)
          $display("FAIL tol_match: cycle %0d idx %0d, want cycle %0d idx %0d",
                   obs_cyc[obs_rd % 128], obs_idx[obs_rd % 128], e.cyc, e.idx);
        else passed++;
        obs_rd++;
      end
    end
    checks++;
    if (obs_rd != obs_wr) begin
      $display("FAIL tol_extra: %0d extra pulses, want 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end else passed++;
    checks++;
    if (pass !== 1'b1) $display("FAIL tol_pass: pass=%b, want 1", pass);
    else passed++;
  endtask

  task automatic test_glitch();
    exp_t e;
    program_entry(0, 1'b0, 1'b0, 16'hAB40);
    hold(20'h0, 10, 1'b0, 0);
    start_seq(1, 0);
    hold({4'h0, 16'hAB40}, 3, 1'b0, 0);
    hold(20'h0, 10, 1'b0, 0);
    checks++;
    if (cur_index !== 3'd0 || busy !== 1'b1)
      $display("FAIL glitch_short: idx=%0d busy=%b, want 0 1", cur_index, busy);
    else passed++;
    hold({4'h0, 16'hAB40}, 5, 1'b1, 1);
    hold(20'h0, 10, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin
        $display("FAIL glitch_match: no pulse, want cycle %0d idx %0d", e.cyc, e.idx);
      end else begin
        if (obs_cyc[obs_rd % 128] !== e.cyc || obs_idx[obs_rd % 128] !== e.idx)
          $display("FAIL glitch_match: cycle %0d idx %0d, want cycle %0d idx %0d",
                   obs_cyc[obs_rd % 128], obs_idx[obs_rd % 128], e.cyc, e.idx);
        else passed++;
        obs_rd++;
      end
    end
    checks++;
    if (obs_rd != obs_wr) begin
      $display("FAIL glitch_extra: %0d extra pulses, want 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    program_entry(1, 1'b0, 1'b0, 16'hAB40);
    hold(20'h0, 10, 1'b0, 0);
    start_seq(2, 0);
    hold({4'h0, 16'hAB40}, 12, 1'b1, 1);
    e = exp_q[$];
    e.cyc = e.cyc + 1;
    e.idx = 2;
    exp_q.push_back(e);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin
        $display("FAIL b2b_match: no pulse, want cycle %0d idx %0d", e.cyc, e.idx);
      end else begin
        if (obs_cyc[obs_rd % 128] !== e.cyc || obs_idx[obs_rd % 128] !== e.idx)
          $display("FAIL b2b_match: cycle %0d idx %0d, want cycle %0d idx %0d",
                   obs_cyc[obs_rd % 128], obs_idx[obs_rd % 128], e.cyc, e.idx);
        else passed++;
        obs_rd++;
      end
    end
    checks++;
    if (obs_rd != obs_wr) begin
      $display("FAIL b2b_extra: %0d extra pulses, want 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end else passed++;
    checks++;
    if (pass !== 1'b1) $display("FAIL b2b_pass: pass=%b, want 1", pass);
    else passed++;
  endtask

  task automatic test_timeout();
    int rise;
    int fail_at;
    program_entry(0, 1'b0, 1'b0, 16'h1234);
    hold(20'h0, 10, 1'b0, 0);
    start_seq(1, 100);
    rise    = cyc;
    fail_at = -1;
    checks++;
    if (busy !== 1'b1) $display("FAIL timeout_busy: busy=%b, want 1", busy);
    else passed++;
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk_i);
      if (fail === 1'b1) begin
        fail_at = cyc;
        break;
      end
    end
    checks++;
    if (fail_at - rise !== 101)
      $display("FAIL timeout_latency: fail after %0d cycles, want 101", fail_at - rise);
    else passed++;
    checks++;
    if (timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0)
      $display("FAIL timeout_flags: timeout=%b pass=%b busy=%b, want 1 0 0",
               timeout, pass, busy);
    else passed++;
  endtask

  task automatic test_count_zero();
    start_seq(0, 0);
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0)
      $display("FAIL count_zero: pass=%b busy=%b fail=%b timeout=%b, want 1 0 0 0",
               pass, busy, fail, timeout);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_reset_midrun();
    test_tolerance();
    test_glitch();
    test_back_to_back();
    test_timeout();
    test_count_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gpio_checkpoint_monitor.md
# gpio_checkpoint_monitor

Synthesizable checkpoint sequencer that consumes the user-project GPIO outputs (`mprj_io[31:16]` checkbits and `mprj_io[35:32]` status) and confirms that a programmed sequence of checkpoint values appears in order. Each value must be held stable for a minimum number of cycles, and the sequence must complete within a per-step timeout. It sits directly downstream of the caravel `mprj_io` pads, in place of the behavioural `wait()` chain used in the stimulus benches, so the same pass/fail decision can run on an FPGA harness or in the user area. A per-entry +1 tolerance absorbs the RTL/GL off-by-one differences in copied values.

## Interface
- `DEPTH`, 8: number of expected-sequence entries (power of two, 2..16).
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a value is considered observed (1..15).
- `TIMEOUT_W`, 24: width of the per-step timeout counter.

- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `gpio_in` in 20: `{status[3:0], checkbits[15:0]}`, asynchronous to `wb_clk_i`.
- `cfg_we` in 1: write one sequence entry; ignored while `busy`.
- `cfg_addr` in log2(DEPTH): entry index.
- `cfg_value` in 16: expected value; for status entries only `[3:0]` is used.
- `cfg_sel` in 1: entry field select; 0 compares checkbits, 1 compares status.
- `cfg_tol` in 1: 1 accepts `value` or `value+1` (16-bit wrap for checkbits, 4-bit wrap for status).
- `cfg_count` in log2(DEPTH)+1: number of entries to check, from 0 to DEPTH; latched on `start`.
- `cfg_timeout` in TIMEOUT_W: maximum cycles allowed per step; 0 disables the timeout. Latched on `start`.
- `start` in 1: one-cycle pulse that arms the sequence; ignored while `busy`.
- `abort` in 1: return to IDLE; has priority over `start`.
- `busy` out 1: sequence armed.
- `matched` out 1: one-cycle pulse when the current entry is satisfied.
- `cur_index` out log2(DEPTH): entry currently awaited.
- `pass` out 1: sticky; all entries matched.
- `fail` out 1: sticky; sequence did not complete.
- `timeout` out 1: sticky; qualifies `fail` as a timeout.

## Operation
- **Input conditioning**
  - `gpio_in` passes through a 2-flop synchronizer into `s2`, then a 1-flop history register `s3`.
  - `stab_cnt` clears to 0 when `s2 != s3`. Otherwise it increments, saturating at `STABLE_CYCLES`.
  - `stable` = (`stab_cnt == STABLE_CYCLES`).
- **Storage**: `DEPTH` x 18-bit register file `{sel, tol, value}`. It is not cleared by reset; contents are retained across runs.
- **FSM states**: IDLE, ARMED, PASS, FAIL.
  - IDLE/PASS/FAIL on `start`, with `cfg_count == 0`: go to PASS.
  - IDLE/PASS/FAIL on `start`, with `cfg_count != 0`: go to ARMED. Set index to 0, clear the timer, and clear `pass`/`fail`/`timeout`.
  - ARMED, when `stable` and the current entry matches the stable sample `s3`:
    - Pulse `matched`, increment the index, and clear the timer.
    - If the index was `count-1`, go to PASS.
  - ARMED, when the timer reaches `cfg_timeout` (timeout nonzero) before a match: go to FAIL and set `timeout`.
  - Any state on `abort`: go to IDLE. Clear `pass`, `fail` and `timeout`; index goes to 0.
- **Match rule**
  - `sel=0`: `s3[15:0] == value`, or (`tol` and `s3[15:0] == value+1` mod 2^16).
  - `sel=1`: `s3[19:16] == value[3:0]`, or (`tol` and `s3[19:16] == value[3:0]+1` mod 16).
- **Consecutive entries**: at most one entry advances per cycle. An already-stable value may satisfy the next entry on the following cycle without any input change.
- **Timer**: counts cycles in ARMED and saturates at all-ones. The timeout and a match in the same cycle resolve as the match.
- **Outputs**: `busy` = ARMED; `pass` = PASS; `fail` = FAIL.

## Timing
- **Reset values**: all outputs 0; FSM IDLE; synchronizer, `stab_cnt` and timer 0.
- **Input-to-match latency**: a change on `gpio_in` sampled at edge k and then held, matching the current entry, produces `matched` high in cycle k+3+STABLE_CYCLES (2 sync + 1 history + STABLE_CYCLES count).
- `pass` asserts in the same cycle as the final `matched`. `busy` deasserts in that cycle.
- `start` to `busy` takes 1 cycle.
- `fail`/`timeout` assert the cycle after the timer equals `cfg_timeout`.
- **Glitch rejection**: a glitch shorter than STABLE_CYCLES+1 synchronized samples never produces a match.
- **Reset mid-sequence**: asynchronous return to all reset values; the register file is unchanged.

## Test plan
- **Basic sequence**
  - Program 5 entries:
    - checkbits 0xAB40
    - status 0xA
    - status 0x5
    - checkbits 0x1968 with tol
    - checkbits 0xAB51
  - Drive the values in order, each held 10 cycles.
  - Required: 5 `matched` pulses and `pass`=1; each pulse at hold-start + 7 with STABLE_CYCLES=4.
- **Tolerance**
  - Drive 0x1969 for the tol entry 0x1968: it matches.
  - Drive 0x196A: no match.
  - A status entry of 0xF with tol accepts 0x0.
- **Glitch**: a 3-cycle pulse of 0xAB40 on a 0x0000 background produces no `matched`; a 5-cycle hold produces one.
- **Timeout**: `cfg_timeout`=100 with the first value never driven → `fail`=1 and `timeout`=1 exactly 101 cycles after `busy` rose; `pass` stays 0.
- **Consecutive/boundary**
  - Two consecutive entries of 0xAB40 with input held produce `matched` on two adjacent cycles.
  - `cfg_count`=0 → `pass` one cycle after `start`.
- **Abort/reset**
  - `abort` at index 2 → IDLE with all flags 0.
  - `wb_rst_i` mid-run → outputs 0 immediately.
  - A re-`start` with no reprogramming reuses the stored entries.
